rr_mux_stream: RTL and testbench

- Parametrised N-way, W-bit stream multiplexer. It is the registered, handshaked successor to the combinational 8-way 16-bit select mux.
- Merges N valid/ready source channels into one output stream through a single output register.
- Two modes: round-robin arbitration, or fixed select like the plain mux.
- Sits between multiple producers and one shared consumer, e.g. register-file or ALU operand paths.

---
 rtl/rr_mux_stream.sv | 84 ++++++++
 tb/tb_rr_mux_stream.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_mux_stream.sv
// N-way valid/ready stream merger with a single registered output stage.
// Grants by round-robin (mode=0) or by fixed channel select (mode=1).
module rr_mux_stream #(
    parameter int N = 8,
    parameter int W = 16,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic [SW-1:0]  out_sel,
    input  logic           out_ready
);

    logic [SW-1:0] ptr;
    logic [SW-1:0] gnt;
    logic          gnt_vld;
    logic [W-1:0]  gnt_data;
    logic          load;
    logic          xfer;

    assign load = ~out_valid | out_ready;
    assign xfer = gnt_vld & load;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt     = '0;
        if (mode) begin
            // An out-of-range sel matches no channel, so it never grants.
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = SW'(i);
                end
            end
        end else begin
            // Scan from farthest to nearest so the nearest requester after ptr wins.
            for (int k = N; k >= 1; k--) begin
                idx = (int'(ptr) + k) % N;
                if (in_valid[idx]) begin
                    gnt_vld = 1'b1;
                    gnt     = SW'(idx);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt] = 1'b1;
        end
    end

    assign gnt_data = in_data[int'(gnt)*W +: W];

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= SW'(N - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_sel   <= gnt;
            if (!mode) begin
                ptr <= gnt;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_stream.sv
// Directed bench for rr_mux_stream: an 8x16 instance and a 3x8 instance.
module tb_rr_mux_stream;

    logic          clk;
    logic          rst_n;

    logic [127:0]  d8;
    logic [7:0]    v8;
    logic [7:0]    r8;
    logic          mode8;
    logic [2:0]    sel8;
    logic [15:0]   od8;
    logic          ov8;
    logic [2:0]    os8;
    logic          ordy8;

    logic [23:0]   d3;
    logic [2:0]    v3;
    logic [2:0]    r3;
    logic          mode3;
    logic [1:0]    sel3;
    logic [7:0]    od3;
    logic          ov3;
    logic [1:0]    os3;
    logic          ordy3;

    int errors = 0;
    int checks = 0;

    rr_mux_stream #(.N(8), .W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .in_data(d8), .in_valid(v8), .in_ready(r8),
        .mode(mode8), .sel(sel8), .out_data(od8), .out_valid(ov8), .out_sel(os8),
        .out_ready(ordy8)
    );

    rr_mux_stream #(.N(3), .W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(r3),
        .mode(mode3), .sel(sel3), .out_data(od3), .out_valid(ov3), .out_sel(os3),
        .out_ready(ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) d8[i*16 +: 16] = 16'h1000 + 16'(i);
        v8 = 8'h00; mode8 = 1'b0; sel8 = 3'd0; ordy8 = 1'b1;
        d3 = {8'h22, 8'h11, 8'h00};
        v3 = 3'b111; mode3 = 1'b1; sel3 = 2'd3; ordy3 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(ov8), 32'h0);
        chk("rst_out_data", 32'(od8), 32'h0);
        chk("rst_out_sel", 32'(os8), 32'h0);
        chk("rst_in_ready_idle", 32'(r8), 32'h0);
        rst_n = 1'b1;

        // Round-robin across all eight channels
        v8 = 8'hFF;
        #1;
        chk("rr_first_ready", 32'(r8), 32'h01);
        chk("rr_no_early_valid", 32'(ov8), 32'h0);
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("rr_valid", 32'(ov8), 32'h1);
            chk("rr_sel", 32'(os8), 32'(k % 8));
            chk("rr_data", 32'(od8), 32'h1000 + 32'(k % 8));
            chk("rr_next_ready", 32'(r8), 32'(8'h01 << ((k + 1) % 8)));
        end

        // Sparse requests with wrap-around: 2, 7, 2
        v8 = 8'b1000_0100;
        #1;
        chk("sparse_ready_2", 32'(r8), 32'h04);
        tick();
        chk("sparse_sel_2", 32'(os8), 32'd2);
        chk("sparse_ready_7", 32'(r8), 32'h80);
        tick();
        chk("sparse_sel_7", 32'(os8), 32'd7);
        chk("sparse_ready_wrap", 32'(r8), 32'h04);
        tick();
        chk("sparse_sel_wrap", 32'(os8), 32'd2);

        // Fixed select on channel 5
        mode8 = 1'b1; sel8 = 3'd5; v8 = 8'hFF;
        d8[5*16 +: 16] = 16'hBEEF;
        #1;
        chk("fix_ready", 32'(r8), 32'h20);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fix_data", 32'(od8), 32'hBEEF);
            chk("fix_sel", 32'(os8), 32'd5);
            chk("fix_ready_hold", 32'(r8), 32'h20);
        end
        d8[5*16 +: 16] = 16'h1005;
        mode8 = 1'b0;
        #1;
        chk("fix_ptr_unchanged", 32'(r8), 32'h08);

        // Backpressure while holding 0x1003
        tick();
        chk("bp_load", 32'(od8), 32'h1003);
        ordy8 = 1'b0;
        #1;
        chk("bp_ready_low", 32'(r8), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_hold_data", 32'(od8), 32'h1003);
            chk("bp_hold_valid", 32'(ov8), 32'h1);
            chk("bp_hold_ready", 32'(r8), 32'h0);
        end
        ordy8 = 1'b1;
        #1;
        chk("bp_release_ready", 32'(r8), 32'h10);
        tick();
        chk("bp_no_bubble_data", 32'(od8), 32'h1004);
        chk("bp_no_bubble_sel", 32'(os8), 32'd4);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ov8), 32'h0);
        chk("arst_data", 32'(od8), 32'h0);
        chk("arst_sel", 32'(os8), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("arst_first_ready", 32'(r8), 32'h01);
        tick();
        chk("arst_first_sel", 32'(os8), 32'd0);
        chk("arst_first_data", 32'(od8), 32'h1000);

        // No requests: drain, hold data, pointer unchanged
        v8 = 8'h00;
        #1;
        chk("idle_ready", 32'(r8), 32'h0);
        tick();
        chk("idle_drain", 32'(ov8), 32'h0);
        chk("idle_hold_data", 32'(od8), 32'h1000);
        chk("idle_hold_sel", 32'(os8), 32'd0);
        v8 = 8'hFF;
        #1;
        chk("idle_ptr_kept", 32'(r8), 32'h02);

        // N=3 instance: sel=3 is out of range and has been applied throughout
        chk("n3_oob_ready", 32'(r3), 32'h0);
        chk("n3_oob_valid", 32'(ov3), 32'h0);
        tick();
        chk("n3_oob_valid_later", 32'(ov3), 32'h0);
        sel3 = 2'd2;
        #1;
        chk("n3_sel2_ready", 32'(r3), 32'h4);
        tick();
        chk("n3_sel2_data", 32'(od3), 32'h22);
        chk("n3_sel2_sel", 32'(os3), 32'd2);
        chk("n3_sel2_valid", 32'(ov3), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
